ghost_mode_ctrl: RTL and testbench

- Global scatter/chase scheduler for all four ghost movers. Counts the shared 60 Hz frame_tick and walks the arcade level-1 mode schedule.
- Drives isChase/isScatter into every ghost block, plus a one-cycle reverse_dir pulse on each mode flip.
- Sits directly upstream of the ghost movers, beside the frame-tick generator.

---
 rtl/ghost_mode_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ghost_mode_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: level-1 scatter/chase schedule shared by all four ghost movers.
// Optional frightened mode is enabled with the GHOST_FRIGHTENED_EN macro.
`default_nettype none

module ghost_mode_ctrl #(
    parameter int START_DELAY_FRAMES   = 300,
    parameter int SCATTER_LONG_FRAMES  = 420,
    parameter int SCATTER_SHORT_FRAMES = 300,
    parameter int CHASE_FRAMES         = 1200,
    parameter int FRIGHT_FRAMES        = 360
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       game_start,
    input  logic       pause,
    input  logic       power_pellet,
    output logic       isChase,
    output logic       isScatter,
    output logic       isFrightened,
    output logic       reverse_dir,
    output logic [2:0] mode_phase,
    output logic       active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [10:0] c_delay_last   = 11'(START_DELAY_FRAMES - 1);
    localparam logic [10:0] c_long_last    = 11'(SCATTER_LONG_FRAMES - 1);
    localparam logic [10:0] c_short_last   = 11'(SCATTER_SHORT_FRAMES - 1);
    localparam logic [10:0] c_chase_last   = 11'(CHASE_FRAMES - 1);
    localparam logic [2:0]  c_final_phase  = 3'd7;

    state_t      r_state, w_state;
    logic [10:0] r_frame_cnt, w_frame_cnt;
    logic [2:0]  r_phase, w_phase;
    logic        r_chase, w_chase;
    logic        r_scatter, w_scatter;
    logic        r_rev, w_rev;
    logic [10:0] w_len_last;

`ifdef GHOST_FRIGHTENED_EN
    localparam logic [10:0] c_fright_last = 11'(FRIGHT_FRAMES - 1);
    logic        r_fright, w_fright;
    logic [10:0] r_fright_cnt, w_fright_cnt;
`else
    logic [11:0] w_unused_fright;
    assign w_unused_fright = {power_pellet, 11'(FRIGHT_FRAMES)};
`endif

    always_comb begin
        w_len_last = c_chase_last;
        case (r_phase)
            3'd0, 3'd2: w_len_last = c_long_last;
            3'd4, 3'd6: w_len_last = c_short_last;
            default:    w_len_last = c_chase_last;
        endcase
    end

    always_comb begin
        w_state     = r_state;
        w_frame_cnt = r_frame_cnt;
        w_phase     = r_phase;
        w_chase     = r_chase;
        w_scatter   = r_scatter;
        w_rev       = 1'b0;
`ifdef GHOST_FRIGHTENED_EN
        w_fright     = r_fright;
        w_fright_cnt = r_fright_cnt;
`endif
        if (game_start) begin
            w_state     = S_DELAY;
            w_frame_cnt = 11'd0;
            w_phase     = 3'd0;
            w_chase     = 1'b0;
            w_scatter   = 1'b0;
`ifdef GHOST_FRIGHTENED_EN
            w_fright     = 1'b0;
            w_fright_cnt = 11'd0;
`endif
        end else if (!pause) begin
            case (r_state)
                S_DELAY: begin
                    if (frame_tick) begin
                        if (r_frame_cnt == c_delay_last) begin
                            w_state     = S_RUN;
                            w_frame_cnt = 11'd0;
                            w_phase     = 3'd0;
                            w_scatter   = 1'b1;
                        end else begin
                            w_frame_cnt = r_frame_cnt + 11'd1;
                        end
                    end
                end
                S_RUN: begin
`ifdef GHOST_FRIGHTENED_EN
                    // While frightened the schedule count is frozen; only the fright timer runs.
                    if (power_pellet) begin
                        w_fright     = 1'b1;
                        w_fright_cnt = 11'd0;
                        w_rev        = 1'b1;
                    end else if (frame_tick && r_fright) begin
                        if (r_fright_cnt == c_fright_last) begin
                            w_fright     = 1'b0;
                            w_fright_cnt = 11'd0;
                        end else begin
                            w_fright_cnt = r_fright_cnt + 11'd1;
                        end
                    end else
`endif
                    if (frame_tick && (r_phase != c_final_phase)) begin
                        if (r_frame_cnt == w_len_last) begin
                            w_phase     = r_phase + 3'd1;
                            w_frame_cnt = 11'd0;
                            w_chase     = ~r_chase;
                            w_scatter   = ~r_scatter;
                            w_rev       = 1'b1;
                        end else begin
                            w_frame_cnt = r_frame_cnt + 11'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 11'd0;
            r_phase     <= 3'd0;
            r_chase     <= 1'b0;
            r_scatter   <= 1'b0;
            r_rev       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_frame_cnt <= w_frame_cnt;
            r_phase     <= w_phase;
            r_chase     <= w_chase;
            r_scatter   <= w_scatter;
            r_rev       <= w_rev;
        end
    end

`ifdef GHOST_FRIGHTENED_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fright     <= 1'b0;
            r_fright_cnt <= 11'd0;
        end else begin
            r_fright     <= w_fright;
            r_fright_cnt <= w_fright_cnt;
        end
    end
    assign isFrightened = r_fright;
`else
    assign isFrightened = 1'b0;
`endif

    assign isChase     = r_chase;
    assign isScatter   = r_scatter;
    assign reverse_dir = r_rev;
    assign mode_phase  = r_phase;
    assign active      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ghost_mode_ctrl.sv
// tb_ghost_mode_ctrl: directed stimulus with a cumulative-tick schedule model and literal checkpoints.
`default_nettype none

module tb_ghost_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       game_start = 1'b0;
    logic       pause = 1'b0;
    logic       power_pellet = 1'b0;
    logic       isChase, isScatter, isFrightened, reverse_dir, active;
    logic [2:0] mode_phase;

    int vectors = 0;
    int errors  = 0;
    int rev_cnt = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    ghost_mode_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .game_start   (game_start),
        .pause        (pause),
        .power_pellet (power_pellet),
        .isChase      (isChase),
        .isScatter    (isScatter),
        .isFrightened (isFrightened),
        .reverse_dir  (reverse_dir),
        .mode_phase   (mode_phase),
        .active       (active)
    );

    // Model: phase is derived from the total number of scheduled ticks spent in RUN.
    int lens [7] = '{420, 1200, 420, 1200, 300, 1200, 300};
    bit m_started, m_running, m_rev, m_fr;
    int m_dt, m_rt, m_ft;

    function automatic int phase_of(int n);
        int p = 0;
        int r = n;
        while (p < 7 && r >= lens[p]) begin
            r = r - lens[p];
            p++;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        int old_p;
        m_rev = 1'b0;
        if (!rst_n) begin
            m_started = 0; m_running = 0; m_fr = 0;
            m_dt = 0; m_rt = 0; m_ft = 0;
        end else if (game_start) begin
            m_started = 1; m_running = 0; m_fr = 0;
            m_dt = 0; m_rt = 0; m_ft = 0;
        end else if (pause) begin
        end else if (m_started && !m_running) begin
            if (frame_tick) begin
                m_dt++;
                if (m_dt == 300) begin
                    m_running = 1;
                    m_rt = 0;
                end
            end
        end else if (m_running) begin
`ifdef GHOST_FRIGHTENED_EN
            if (power_pellet) begin
                m_fr = 1; m_ft = 0; m_rev = 1;
            end else if (frame_tick && m_fr) begin
                m_ft++;
                if (m_ft == 360) begin
                    m_fr = 0; m_ft = 0;
                end
            end else
`endif
            if (frame_tick) begin
                old_p = phase_of(m_rt);
                m_rt++;
                if (phase_of(m_rt) != old_p) m_rev = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] act_v, exp_v;
        int p;
        if (chk_en) begin
            p = m_running ? phase_of(m_rt) : 0;
            exp_v = {m_started, 3'(p), m_running && (p % 2 == 1),
                     m_running && (p % 2 == 0), m_rev, m_fr};
            act_v = {active, mode_phase, isChase, isScatter, reverse_dir, isFrightened};
            vectors++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_model t=%0t dut=%b model=%b (act,phase,chase,scatter,rev,fright)",
                         $time, act_v, exp_v);
            end
            if (reverse_dir === 1'b1) rev_cnt++;
        end
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(bit t, bit g, bit p, bit pp);
        @(negedge clk);
        frame_tick = t; game_start = g; pause = p; power_pellet = pp;
    endtask

    task automatic tick_n(int n);
        repeat (n) begin
            drive(1, 0, 0, 0);
            drive(0, 0, 0, 0);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rc;
        rst_n = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_active", int'(active), 0);
        chk("reset_phase", int'(mode_phase), 0);
        chk("reset_modes", int'({isChase, isScatter, reverse_dir, isFrightened}), 0);
        rst_n = 1'b1;

        // No start: stays idle regardless of ticks.
        tick_n(1000);
        settle();
        chk("idle_active", int'(active), 0);
        chk("idle_modes", int'({isChase, isScatter}), 0);

        // Start delay and first scatter.
        rc = rev_cnt;
        drive(0, 1, 0, 0);
        tick_n(299);
        settle();
        chk("delay_active", int'(active), 1);
        chk("delay_scatter", int'(isScatter), 0);
        tick_n(1);
        settle();
        chk("scatter0_rise", int'(isScatter), 1);
        chk("scatter0_phase", int'(mode_phase), 0);
        chk("scatter0_no_rev", rev_cnt - rc, 0);

        // Full schedule walk.
        tick_n(419);
        settle();
        chk("scatter0_last", int'(mode_phase), 0);
        tick_n(1);
        settle();
        chk("chase1_phase", int'(mode_phase), 1);
        chk("chase1_modes", int'({isChase, isScatter}), 2);
        chk("chase1_one_rev", rev_cnt - rc, 1);
        tick_n(4620);
        settle();
        chk("phase7_reached", int'(mode_phase), 7);
        chk("phase7_revs", rev_cnt - rc, 7);
        tick_n(5000);
        settle();
        chk("phase7_stays", int'(mode_phase), 7);
        chk("phase7_chase", int'(isChase), 1);
        chk("phase7_revs_final", rev_cnt - rc, 7);

        // Pause in phase 1 at frame_cnt 600.
        drive(0, 1, 0, 0);
        tick_n(300 + 420 + 600);
        repeat (50) begin
            drive(1, 0, 1, 0);
            drive(0, 0, 1, 0);
        end
        drive(0, 0, 0, 0);
        settle();
        chk("pause_phase", int'(mode_phase), 1);
        tick_n(599);
        settle();
        chk("pause_chase_held", int'(mode_phase), 1);
        tick_n(1);
        settle();
        chk("pause_chase_end", int'(mode_phase), 2);

        // Restart on the terminal tick of phase 3.
        drive(0, 1, 0, 0);
        tick_n(300 + 420 + 1200 + 420 + 1199);
        settle();
        chk("pre_restart_phase", int'(mode_phase), 3);
        drive(1, 1, 0, 0);
        settle();
        chk("restart_phase", int'(mode_phase), 0);
        chk("restart_modes", int'({isChase, isScatter}), 0);
        chk("restart_no_rev", int'(reverse_dir), 0);
        chk("restart_active", int'(active), 1);
        drive(0, 0, 0, 0);
        tick_n(300);
        settle();
        chk("restart_scatter", int'(isScatter), 1);

`ifdef GHOST_FRIGHTENED_EN
        // Frightened during phase 0, extended by a second pellet.
        drive(0, 1, 0, 0);
        tick_n(300 + 100);
        drive(0, 0, 0, 1);
        settle();
        chk("fright_set", int'(isFrightened), 1);
        chk("fright_rev", int'(reverse_dir), 1);
        drive(0, 0, 0, 0);
        tick_n(200);
        drive(0, 0, 0, 1);
        settle();
        chk("fright_rev2", int'(reverse_dir), 1);
        drive(0, 0, 0, 0);
        tick_n(359);
        settle();
        chk("fright_held", int'(isFrightened), 1);
        chk("fright_scatter_hold", int'(isScatter), 1);
        tick_n(1);
        settle();
        chk("fright_clear", int'(isFrightened), 0);
        tick_n(319);
        settle();
        chk("fright_resume_p0", int'(mode_phase), 0);
        tick_n(1);
        settle();
        chk("fright_resume_p1", int'(mode_phase), 1);
`else
        // Pellets have no effect without the frightened feature.
        drive(0, 0, 0, 1);
        settle();
        chk("pellet_ignored", int'({isFrightened, reverse_dir}), 0);
`endif

        // Reset mid-phase.
        @(negedge clk);
        rst_n = 1'b0;
        settle();
        chk("midreset_active", int'(active), 0);
        chk("midreset_modes", int'({isChase, isScatter, mode_phase}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
